simps_seq_ctrl: RTL
===================

// Module: simps_seq_ctrl
// PURPOSE
//  Parametrised top-level sequencer: the reset/program/active control FSM lifted out of the SIMPS top level.
//  Sequences UFM reset, CSR and pot config, UFM program write/read, PSU/SigGen load, and inactive/active modes.
//  Adds per-state watchdog timeouts with a FAULT state.
//  Adds N_OVR generic front-end override channels, latched synchronously and cleared only by reset.
//  Top level feeds it debounced switch levels/rise pulses and subsystem done flags.
//  Outputs drive PS_EN, FG_EN, relays and the LED mode.
// PARAMETERS
//  N_OVR        4           number of override channels (ch0=PS_EN, ch1=FG_EN, ch2/3=relays by convention)
//  GATE_MASK    4'b0001     bit i=1: channel i override value forced 0 unless state==ACTIVE
//  UFM_RST_CYC  4           cycles ufm_reset_n held low in UFM_RST (>=1)
//  TMO_W        24          width of watchdog counter
//  TMO_CYC      12_500_000  watchdog limit in CLK_25M cycles (0.5 s); must be < 2**TMO_W
// PORTS
//  CLK_25M         in   1      system clock
//  reset           in   1      synchronous, active-high (debounced reset rise pulse)
//  res_sw          in   1      debounced reset switch level
//  enable          in   1      debounced enable switch level
//  enable_rise     in   1      one-cycle pulse on enable rising edge
//  init_done_i     in   1      psPot and SGclock reset sequences finished
//  cfg_done_i      in   1      CSR config and pot initial config finished
//  write_done_i    in   1      UFM program write finished
//  read_done_i     in   1      UFM readback into registers finished
//  load_done_i     in   1      pot reference and SG frequency/phase written
//  sgclk_stopped_i in   1      SG clock generator idle/disabled
//  sgclk_running_i in   1      SG clock generator running
//  ovr_valid       in   N_OVR  per-channel override write strobe from protocol block
//  ovr_value       in   N_OVR  per-channel override value, sampled with ovr_valid
//  chan_fsm        in   N_OVR  per-channel FSM-owned value (top ties ch0=ps_en, ch1=fg_en)
//  chan_out        out  N_OVR  resolved channel outputs
//  ps_en           out  1      FSM power-supply enable
//  fg_en           out  1      FSM function-generator enable
//  ufm_reset_n     out  1      UFM/ADC reset, active-low
//  led_mode        out  2      00 off, 01 blink, 10 on
//  state           out  4      current FSM state encoding
//  fault           out  1      high while in FAULT
//  fault_code      out  4      state in which the watchdog expired
// BEHAVIOUR
//  Reset priority: reset overrides every other input on that edge.
//  On reset: state=IDLE(0), ps_en=fg_en=0, ufm_reset_n=1, led_mode=01, fault=0, fault_code=0,
//   watchdog=0, all ovr_active=0 and ovr_val=0.
//  All outputs are registered except chan_out, which is a combinational resolve of registers and chan_fsm.
//  States and transitions (evaluated each edge):
//   0 IDLE       -> 1 when enable_rise && res_sw.
//   1 UFM_RST    ufm_reset_n=0 for the first UFM_RST_CYC cycles, then 1.
//                -> 2 when low-phase complete && init_done_i.
//   2 CFG        -> 3 on cfg_done_i.
//   3 PROG_WR    led_mode=01; -> 4 on write_done_i, setting led_mode=10 on the same edge.
//   4 PROG_RD    -> 5 on read_done_i.
//   5 LOAD       -> 6 when load_done_i && !res_sw && !enable.
//   6 INACTIVE   ps_en=0, fg_en=0; -> 7 when sgclk_stopped_i && !res_sw && enable_rise.
//   7 ACTIVE     ps_en=1 from the first cycle in state.
//                fg_en=1 once sgclk_running_i && enable && !res_sw.
//                -> 4 when sgclk_running_i && !enable && !res_sw; ps_en and fg_en clear on that edge.
//   8 FAULT      ps_en=fg_en=0, ufm_reset_n=1, led_mode=01, fault=1; exits only via reset.
//  Encodings 9-15 are illegal and go to FAULT with fault_code=state.
//  Watchdog:
//   - runs in states 1-4 and clears on every state change.
//   - when watchdog==TMO_CYC-1 and the exit condition is false: -> FAULT, fault_code=state.
//   - an exit condition true on the expiry cycle wins; no fault is raised.
//   - states 0, 5, 6, 7 are untimed because they wait on the user.
//  Override channel i:
//   - ovr_valid[i] sets ovr_active[i]=1 and ovr_val[i]=ovr_value[i]; takes effect the next cycle.
//   - ovr_valid[i] together with reset: reset wins.
//   - chan_out[i] = ovr_active ? ((GATE_MASK[i] && state!=7) ? 0 : ovr_val[i]) : chan_fsm[i].
//   - in FAULT, chan_out of every GATE_MASK channel is 0 regardless of override.
//  Reset mid-sequence, from any state: next cycle is IDLE with reset values; overrides are dropped.
// TESTING
//  T1 nominal: IDLE, res_sw=1 + enable_rise, pulse each done flag in turn, then res_sw=0/enable=0 and enable_rise.
//     -> states 0,1,2,3,4,5,6,7; ufm_reset_n low exactly 4 cycles.
//     -> ps_en=1 one cycle after entering 7; fg_en=1 after sgclk_running_i.
//  T2 watchdog: TMO_CYC=100, hold cfg_done_i=0 in CFG -> FAULT after 100 cycles, fault_code=2, ps_en=0.
//     Repeat with cfg_done_i asserted on cycle 99 -> state 3, fault=0.
//  T3 exit ACTIVE: in 7 with sgclk_running_i=1, drop enable -> state 4 next edge, ps_en=fg_en=0.
//  T4 override gating: ovr_valid=4'b0001, ovr_value=1 in INACTIVE -> chan_out[0]=0.
//     Enter ACTIVE -> chan_out[0]=1.
//     ovr_valid[2]=1, value 1 -> chan_out[2]=1 in any state, ignoring chan_fsm[2].
//  T5 reset mid-PROG_WR with overrides active -> state 0, led_mode=01, all ovr_active=0, chan_out=chan_fsm.
//  T6 simultaneous: in INACTIVE, enable_rise with res_sw=1 -> stays 6.
//     ovr_valid and reset on the same edge -> override not latched.

Source files
------------

// File: rtl/simps_seq_ctrl.sv
// SIMPS top-level sequencer: UFM reset, config, program write/read, load and
// inactive/active modes, with per-state watchdog, FAULT state and override channels.
module simps_seq_ctrl #(
  parameter int               N_OVR       = 4,
  parameter logic [N_OVR-1:0] GATE_MASK   = N_OVR'(1),
  parameter int               UFM_RST_CYC = 4,
  parameter int               TMO_W       = 24,
  parameter int               TMO_CYC     = 12_500_000
) (
  input  logic             CLK_25M,
  input  logic             reset,
  input  logic             res_sw,
  input  logic             enable,
  input  logic             enable_rise,
  input  logic             init_done_i,
  input  logic             cfg_done_i,
  input  logic             write_done_i,
  input  logic             read_done_i,
  input  logic             load_done_i,
  input  logic             sgclk_stopped_i,
  input  logic             sgclk_running_i,
  input  logic [N_OVR-1:0] ovr_valid,
  input  logic [N_OVR-1:0] ovr_value,
  input  logic [N_OVR-1:0] chan_fsm,
  output logic [N_OVR-1:0] chan_out,
  output logic             ps_en,
  output logic             fg_en,
  output logic             ufm_reset_n,
  output logic [1:0]       led_mode,
  output logic [3:0]       state,
  output logic             fault,
  output logic [3:0]       fault_code
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_UFM_RST  = 4'd1,
    S_CFG      = 4'd2,
    S_PROG_WR  = 4'd3,
    S_PROG_RD  = 4'd4,
    S_LOAD     = 4'd5,
    S_INACTIVE = 4'd6,
    S_ACTIVE   = 4'd7,
    S_FAULT    = 4'd8
  } state_t;

  localparam int               RC_W     = $clog2(UFM_RST_CYC + 1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(UFM_RST_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  localparam logic [1:0] LED_OFF   = 2'b00;
  localparam logic [1:0] LED_BLINK = 2'b01;
  localparam logic [1:0] LED_ON    = 2'b10;

  state_t           state_q, nxt_state;
  logic [TMO_W-1:0] wd_q, nxt_wd;
  logic [RC_W-1:0]  rst_cnt_q, nxt_rst_cnt;
  logic             nxt_ps, nxt_fg, nxt_ufm, nxt_fault;
  logic [1:0]       nxt_led;
  logic [3:0]       nxt_code;
  logic             timed, exit_ok;

  // Override strobes carry no ready: ovr_valid is a write strobe that is
  // always accepted on the edge it is seen (reset on the same edge wins).
  logic [N_OVR-1:0] ovr_active, ovr_val;

  assign state = state_q;

  always_ff @(posedge CLK_25M) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wd_q        <= '0;
      rst_cnt_q   <= '0;
      ps_en       <= 1'b0;
      fg_en       <= 1'b0;
      ufm_reset_n <= 1'b1;
      led_mode    <= LED_BLINK;
      fault       <= 1'b0;
      fault_code  <= 4'd0;
    end else begin
      state_q     <= nxt_state;
      wd_q        <= nxt_wd;
      rst_cnt_q   <= nxt_rst_cnt;
      ps_en       <= nxt_ps;
      fg_en       <= nxt_fg;
      ufm_reset_n <= nxt_ufm;
      led_mode    <= nxt_led;
      fault       <= nxt_fault;
      fault_code  <= nxt_code;
    end
  end

  always_comb begin
    nxt_state   = state_q;
    nxt_rst_cnt = rst_cnt_q;
    nxt_ps      = ps_en;
    nxt_fg      = fg_en;
    nxt_ufm     = ufm_reset_n;
    nxt_led     = led_mode;
    nxt_fault   = fault;
    nxt_code    = fault_code;
    timed       = 1'b0;
    exit_ok     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable_rise && res_sw) begin
          nxt_state   = S_UFM_RST;
          nxt_ufm     = 1'b0;
          nxt_rst_cnt = '0;
        end
      end
      S_UFM_RST: begin
        timed = 1'b1;
        // ufm_reset_n returning high marks the end of the low phase.
        exit_ok = ufm_reset_n && init_done_i;
        if (!ufm_reset_n) begin
          if (rst_cnt_q == RC_LAST) nxt_ufm = 1'b1;
          else                      nxt_rst_cnt = rst_cnt_q + 1'b1;
        end
        if (exit_ok) nxt_state = S_CFG;
      end
      S_CFG: begin
        timed   = 1'b1;
        exit_ok = cfg_done_i;
        if (exit_ok) nxt_state = S_PROG_WR;
      end
      S_PROG_WR: begin
        timed   = 1'b1;
        exit_ok = write_done_i;
        nxt_led = LED_BLINK;
        if (exit_ok) begin
          nxt_state = S_PROG_RD;
          nxt_led   = LED_ON;
        end
      end
      S_PROG_RD: begin
        timed   = 1'b1;
        exit_ok = read_done_i;
        if (exit_ok) nxt_state = S_LOAD;
      end
      S_LOAD: begin
        if (load_done_i && !res_sw && !enable) nxt_state = S_INACTIVE;
      end
      S_INACTIVE: begin
        nxt_ps = 1'b0;
        nxt_fg = 1'b0;
        if (sgclk_stopped_i && !res_sw && enable_rise) begin
          nxt_state = S_ACTIVE;
          nxt_ps    = 1'b1;
        end
      end
      S_ACTIVE: begin
        nxt_ps = 1'b1;
        if (sgclk_running_i && enable && !res_sw) nxt_fg = 1'b1;
        if (sgclk_running_i && !enable && !res_sw) begin
          nxt_state = S_PROG_RD;
          nxt_ps    = 1'b0;
          nxt_fg    = 1'b0;
        end
      end
      S_FAULT: begin
        nxt_state = S_FAULT;
      end
      default: begin
        nxt_state = S_FAULT;
        nxt_code  = state_q;
      end
    endcase

    // An exit condition seen on the expiry cycle takes precedence.
    if (timed && !exit_ok && (wd_q == TMO_LAST)) begin
      nxt_state = S_FAULT;
      nxt_code  = state_q;
    end

    if (nxt_state == S_FAULT) begin
      nxt_ps    = 1'b0;
      nxt_fg    = 1'b0;
      nxt_ufm   = 1'b1;
      nxt_led   = LED_BLINK;
      nxt_fault = 1'b1;
    end

    nxt_wd = (timed && (nxt_state == state_q)) ? wd_q + 1'b1 : '0;
  end

  always_ff @(posedge CLK_25M) begin
    if (reset) begin
      ovr_active <= '0;
      ovr_val    <= '0;
    end else begin
      ovr_active <= ovr_active | ovr_valid;
      ovr_val    <= (ovr_val & ~ovr_valid) | (ovr_value & ovr_valid);
    end
  end

  always_comb begin
    chan_out = '0;
    for (int i = 0; i < N_OVR; i++) begin
      if (GATE_MASK[i] && (state_q == S_FAULT))
        chan_out[i] = 1'b0;
      else if (ovr_active[i])
        chan_out[i] = (GATE_MASK[i] && (state_q != S_ACTIVE)) ? 1'b0 : ovr_val[i];
      else
        chan_out[i] = chan_fsm[i];
    end
  end

  logic unused_led_off;
  assign unused_led_off = ^LED_OFF;

endmodule
